// File: rtl/regbank_wb_ctrl_pkg.sv
// rtl/regbank_wb_ctrl_pkg.sv - shared widths, x0 index and writeback source encoding
package regbank_wb_ctrl_pkg;

   localparam int WB_ADDR_W    = 5;
   localparam int WB_DATA_W    = 32;
   localparam int WB_LSU_DEPTH = 2;
   localparam int X0_IDX       = 0;

   typedef enum logic [1:0] {
      SRC_IDLE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_LSU  = 2'd2
   } wb_src_e;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/regbank_wb_ctrl_wb_fifo.sv
// rtl/regbank_wb_ctrl_wb_fifo.sv - small synchronous FIFO holding LSU {rd, data} results
module wb_fifo
   import regbank_wb_ctrl_pkg::*;
#(
   parameter int DW    = WB_ADDR_W + WB_DATA_W,
   parameter int DEPTH = WB_LSU_DEPTH
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_push,
   input  logic                        i_pop,
   input  logic [DW-1:0]               i_wdata,
   output logic [DW-1:0]               o_rdata,
   output logic                        o_full,
   output logic                        o_empty,
   output logic [cnt_width(DEPTH)-1:0] o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   // a full FIFO refuses the push even when it is popping the same cycle
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/regbank_wb_ctrl.sv
// rtl/regbank_wb_ctrl.sv - REGBank write-port driver (ALU/LSU merge, busy scoreboard; WB_BYPASS_EN adds forwarding)
module regbank_wb_ctrl
   import regbank_wb_ctrl_pkg::*;
#(
   parameter int WIDTH_ADDR_LENGTH = WB_ADDR_W,
   parameter int WIDTH_DATA_LENGTH = WB_DATA_W,
   parameter int LSU_DEPTH         = WB_LSU_DEPTH
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              issue_valid,
   input  logic [WIDTH_ADDR_LENGTH-1:0]      issue_rd,
   input  logic                              alu_valid,
   input  logic [WIDTH_ADDR_LENGTH-1:0]      alu_rd,
   input  logic [WIDTH_DATA_LENGTH-1:0]      alu_data,
   input  logic                              lsu_valid,
   output logic                              lsu_ready,
   input  logic [WIDTH_ADDR_LENGTH-1:0]      lsu_rd,
   input  logic [WIDTH_DATA_LENGTH-1:0]      lsu_data,
   output logic                              RegWEn,
   output logic [WIDTH_ADDR_LENGTH-1:0]      AddrD,
   output logic [WIDTH_DATA_LENGTH-1:0]      DataD,
   output logic [2**WIDTH_ADDR_LENGTH-1:0]   busy
`ifdef WB_BYPASS_EN
   ,
   input  logic [WIDTH_ADDR_LENGTH-1:0]      AddrA,
   input  logic [WIDTH_ADDR_LENGTH-1:0]      AddrB,
   output logic                              fwdA_hit,
   output logic                              fwdB_hit,
   output logic [WIDTH_DATA_LENGTH-1:0]      fwdA_data,
   output logic [WIDTH_DATA_LENGTH-1:0]      fwdB_data
`endif
);

   localparam int AW    = WIDTH_ADDR_LENGTH;
   localparam int DWD   = WIDTH_DATA_LENGTH;
   localparam int EW    = AW + DWD;
   localparam int NREG  = 2**AW;
   localparam int CNT_W = cnt_width(LSU_DEPTH);
   localparam logic [AW-1:0] X0 = AW'(X0_IDX);

   logic [EW-1:0]    w_fifo_rdata;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [CNT_W-1:0] w_fifo_count;
   logic             w_fifo_push;
   logic             w_fifo_pop;
   wb_src_e          w_src;
   logic [AW-1:0]    w_sel_rd;
   logic [DWD-1:0]   w_sel_data;
   logic [NREG-1:0]  w_busy_next;

   logic             r_wen;
   logic [AW-1:0]    r_addr;
   logic [DWD-1:0]   r_data;
   logic [NREG-1:0]  r_busy;

   assign lsu_ready   = (w_fifo_count < CNT_W'(LSU_DEPTH));
   assign w_fifo_push = lsu_valid && !w_fifo_full;
   assign w_fifo_pop  = (w_src == SRC_LSU);

   wb_fifo #(
      .DW    (EW),
      .DEPTH (LSU_DEPTH)
   ) u_wb_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_fifo_push),
      .i_pop   (w_fifo_pop),
      .i_wdata ({lsu_rd, lsu_data}),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   // ALU has no backpressure, so it always wins; the pipeline leaves gaps for the FIFO
   always_comb begin
      w_src      = SRC_IDLE;
      w_sel_rd   = alu_rd;
      w_sel_data = alu_data;
      if (alu_valid) begin
         w_src = SRC_ALU;
      end else if (!w_fifo_empty) begin
         w_src      = SRC_LSU;
         w_sel_rd   = w_fifo_rdata[EW-1:DWD];
         w_sel_data = w_fifo_rdata[DWD-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wen  <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else if (w_src != SRC_IDLE) begin
         r_wen  <= (w_sel_rd != X0);
         r_addr <= w_sel_rd;
         r_data <= w_sel_data;
      end else begin
         r_wen  <= 1'b0;
      end
   end

   // set after clear: a re-issue in the retire cycle belongs to a newer instruction
   always_comb begin
      w_busy_next = r_busy;
      if (r_wen)
         w_busy_next[r_addr] = 1'b0;
      if (issue_valid && (issue_rd != X0))
         w_busy_next[issue_rd] = 1'b1;
      w_busy_next[X0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_busy <= '0;
      else
         r_busy <= w_busy_next;
   end

   assign RegWEn = r_wen;
   assign AddrD  = r_addr;
   assign DataD  = r_data;
   assign busy   = r_busy;

`ifdef WB_BYPASS_EN
   assign fwdA_hit  = r_wen && (r_addr == AddrA) && (AddrA != X0);
   assign fwdB_hit  = r_wen && (r_addr == AddrB) && (AddrB != X0);
   assign fwdA_data = r_data;
   assign fwdB_data = r_data;
`endif

endmodule

// File: tb/tb_regbank_wb_ctrl.sv
// tb/tb_regbank_wb_ctrl.sv - scoreboard bench for regbank_wb_ctrl against a queue-level model
module tb_regbank_wb_ctrl;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        RegWEn;
   logic [4:0]  AddrD;
   logic [31:0] DataD;
   logic [31:0] busy;

   regbank_wb_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .RegWEn      (RegWEn),
      .AddrD       (AddrD),
      .DataD       (DataD),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [4:0]  rd;
      logic [31:0] d;
   } wr_t;

   wr_t         sb[$];
   logic [36:0] mq[$];
   logic [31:0] m_busy;
   logic        m_wen_now;
   logic [4:0]  m_addr_now;
   logic [4:0]  m_addr_held;
   logic [31:0] m_data_held;
   int          cyc;
   bit          mon_en;
   int          n_vec;
   int          n_bad;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // one clock of stimulus; the model decides which result lands next cycle
   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic iv, input logic [4:0] ird);
      bit          exp_ready;
      bit          sel_v;
      logic [4:0]  sel_rd;
      logic [31:0] sel_d;
      logic [36:0] e;
      logic [31:0] nb;
      wr_t         w;
      alu_valid = av; alu_rd = ard; alu_data = adat;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
      issue_valid = iv; issue_rd = ird;
      exp_ready = (mq.size() < DEPTH);
      #1;
      chk("lsu_ready", lsu_ready, exp_ready);
      sel_v = 1'b0; sel_rd = 5'd0; sel_d = 32'd0;
      if (av) begin
         sel_v = 1'b1; sel_rd = ard; sel_d = adat;
      end else if (mq.size() > 0) begin
         e = mq.pop_front();
         sel_v = 1'b1; sel_rd = e[36:32]; sel_d = e[31:0];
      end
      if (lv && exp_ready)
         mq.push_back({lrd, ldat});
      if (sel_v && sel_rd != 5'd0) begin
         w.cyc = cyc + 1; w.rd = sel_rd; w.d = sel_d;
         sb.push_back(w);
      end
      nb = m_busy;
      if (m_wen_now) nb[m_addr_now] = 1'b0;
      if (iv && ird != 5'd0) nb[ird] = 1'b1;
      @(posedge clk);
      cyc++;
      m_busy = nb;
      m_wen_now = sel_v && (sel_rd != 5'd0);
      m_addr_now = sel_rd;
      if (sel_v) begin
         m_addr_held = sel_rd;
         m_data_held = sel_d;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
   endtask

   always @(negedge clk) begin
      wr_t w;
      if (mon_en && !rst) begin
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            w = sb.pop_front();
            chk("RegWEn_due", RegWEn, 1'b1);
            chk("AddrD", AddrD, w.rd);
            chk("DataD", DataD, w.d);
         end else begin
            chk("RegWEn_idle", RegWEn, 1'b0);
            chk("AddrD_hold", AddrD, m_addr_held);
            chk("DataD_hold", DataD, m_data_held);
         end
         chk("busy", busy, m_busy);
      end
   end

   initial begin
      n_vec = 0; n_bad = 0; cyc = 0; mon_en = 0;
      m_busy = '0; m_wen_now = 0; m_addr_now = '0; m_addr_held = '0; m_data_held = '0;
      rst = 1'b1;
      issue_valid = 0; issue_rd = '0; alu_valid = 0; alu_rd = '0; alu_data = '0;
      lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
      #1;
      chk("rst_RegWEn", RegWEn, 1'b0);
      chk("rst_AddrD", AddrD, 5'd0);
      chk("rst_DataD", DataD, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_lsu_ready", lsu_ready, 1'b1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1;

      step(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      idle(1);
      step(1'b1, 5'd4, 32'h0000_0444, 1'b1, 5'd5, 32'h0000_0555, 1'b0, 5'd0);
      idle(3);
      step(1'b1, 5'd10, 32'hA0A0_0010, 1'b1, 5'd11, 32'hB0B0_0011, 1'b0, 5'd0);
      step(1'b1, 5'd12, 32'hA0A0_0012, 1'b1, 5'd13, 32'hB0B0_0013, 1'b0, 5'd0);
      step(1'b1, 5'd14, 32'hA0A0_0014, 1'b1, 5'd15, 32'hB0B0_0015, 1'b0, 5'd0);
      idle(4);
      step(1'b1, 5'd0, 32'hFFFF_AAAA, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
      idle(1);
      chk("busy0_after_x0_issue", busy[0], 1'b0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      chk("busy7_set", busy[7], 1'b1);
      step(1'b1, 5'd7, 32'h0000_0777, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      chk("busy7_set_wins", busy[7], 1'b1);
      idle(2);

      step(1'b1, 5'd20, 32'h2020_2020, 1'b1, 5'd21, 32'h2121_2121, 1'b1, 5'd21);
      step(1'b1, 5'd22, 32'h2222_2222, 1'b1, 5'd23, 32'h2323_2323, 1'b1, 5'd23);
      idle(1);
      #2;
      mon_en = 0;
      rst = 1'b1;
      #1;
      chk("async_rst_RegWEn", RegWEn, 1'b0);
      chk("async_rst_AddrD", AddrD, 5'd0);
      chk("async_rst_DataD", DataD, 32'd0);
      chk("async_rst_busy", busy, 32'd0);
      chk("async_rst_lsu_ready", lsu_ready, 1'b1);
      sb.delete(); mq.delete();
      m_busy = '0; m_wen_now = 0; m_addr_now = '0; m_addr_held = '0; m_data_held = '0;
      @(posedge clk);
      cyc++;
      #1;
      rst = 1'b0;
      mon_en = 1;

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)));
      end
      idle(6);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
